// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Purpose  : Shares one combinational 32-bit ALU (add/AND/OR/XOR with carry,
//            overflow and zero flags) between two requesters using
//            round-robin arbitration. The granted requester's operands drive
//            the ALU, and the result is captured in a one-entry response
//            register. That register is returned to the originating
//            requester over per-requester valid/ready.
// Ports    : clk, rst_n           - clock, async active-low reset
//            req_valid_i/ready_o  - per-requester request handshake (bit i)
//            req{0,1}_a_i/_b_i    - operands per requester
//            req_cin_i, req_sign_i- carry-in / signed-overflow mode (bit i)
//            req{0,1}_oper_i      - 00 add, 01 AND, 10 OR, 11 XOR
//            rsp_valid_o/ready_i  - per-requester response handshake (bit i)
//            rsp_out_o, rsp_zero_o, rsp_ofl_o, rsp_cout_o - registered result
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
  parameter int WIDTH  = 32,
  parameter int OPER_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [WIDTH-1:0]  req0_a_i,
  input  logic [WIDTH-1:0]  req1_a_i,
  input  logic [WIDTH-1:0]  req0_b_i,
  input  logic [WIDTH-1:0]  req1_b_i,
  input  logic [1:0]        req_cin_i,
  input  logic [OPER_W-1:0] req0_oper_i,
  input  logic [OPER_W-1:0] req1_oper_i,
  input  logic [1:0]        req_sign_i,
  output logic [1:0]        rsp_valid_o,
  input  logic [1:0]        rsp_ready_i,
  output logic [WIDTH-1:0]  rsp_out_o,
  output logic              rsp_zero_o,
  output logic              rsp_ofl_o,
  output logic              rsp_cout_o
);

  localparam logic [OPER_W-1:0] C_OP_ADD = OPER_W'(0);
  localparam logic [OPER_W-1:0] C_OP_AND = OPER_W'(1);
  localparam logic [OPER_W-1:0] C_OP_OR  = OPER_W'(2);
  localparam logic [OPER_W-1:0] C_OP_XOR = OPER_W'(3);

  // Registered state
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_out_q,   rsp_out_d;
  logic             rsp_zero_q,  rsp_zero_d;
  logic             rsp_ofl_q,   rsp_ofl_d;
  logic             rsp_cout_q,  rsp_cout_d;
  logic             last_grant_q, last_grant_d;

  // Arbitration
  logic w_gnt;        // index of the requester that would be granted
  logic w_any;
  logic w_drain;
  logic w_slot_free;
  logic w_accept;

  assign w_any = |req_valid_i;
  // Contended: the one not served last; otherwise whichever bit is set.
  assign w_gnt = (&req_valid_i) ? ~last_grant_q : req_valid_i[1];
  // Only the owner's rsp_ready matters since rsp_valid_q is one-hot or zero.
  assign w_drain     = |(rsp_valid_q & rsp_ready_i);
  assign w_slot_free = (rsp_valid_q == 2'b00) | w_drain;
  // rst_n gating keeps req_ready low for the whole reset window, when the
  // cleared slot would otherwise look free.
  assign w_accept    = w_any & w_slot_free & rst_n;
  assign req_ready_o = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

  // Operand mux from the granted requester
  logic [WIDTH-1:0]  w_a, w_b;
  logic              w_cin, w_sign;
  logic [OPER_W-1:0] w_oper;

  assign w_a    = w_gnt ? req1_a_i    : req0_a_i;
  assign w_b    = w_gnt ? req1_b_i    : req0_b_i;
  assign w_cin  = w_gnt ? req_cin_i[1]  : req_cin_i[0];
  assign w_sign = w_gnt ? req_sign_i[1] : req_sign_i[0];
  assign w_oper = w_gnt ? req1_oper_i : req0_oper_i;

  // Shared ALU
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_ofl, w_cout;

  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    w_res  = w_sum[WIDTH-1:0];
    w_ofl  = 1'b0;
    w_cout = 1'b0;
    case (w_oper)
      C_OP_AND: w_res = w_a & w_b;
      C_OP_OR:  w_res = w_a | w_b;
      C_OP_XOR: w_res = w_a ^ w_b;
      C_OP_ADD: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        // Signed overflow: operands share a sign that the result lacks.
        w_ofl  = w_sign ? ((w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != w_a[WIDTH-1]))
                        : w_sum[WIDTH];
      end
      default: w_res = w_sum[WIDTH-1:0];
    endcase
  end

  // Next state
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_out_d    = rsp_out_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ofl_d    = rsp_ofl_q;
    rsp_cout_d   = rsp_cout_q;
    last_grant_d = last_grant_q;
    if (w_accept) begin
      rsp_valid_d  = w_gnt ? 2'b10 : 2'b01;
      rsp_out_d    = w_res;
      rsp_zero_d   = (w_res == '0);
      rsp_ofl_d    = w_ofl;
      rsp_cout_d   = w_cout;
      last_grant_d = w_gnt;
    end else if (w_drain) begin
      rsp_valid_d  = 2'b00;
    end
  end

  // last_grant resets to 1 so the first contended grant goes to requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 2'b00;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ofl_q    <= 1'b0;
      rsp_cout_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_out_q    <= rsp_out_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ofl_q    <= rsp_ofl_d;
      rsp_cout_q   <= rsp_cout_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_out_o   = rsp_out_q;
  assign rsp_zero_o  = rsp_zero_q;
  assign rsp_ofl_o   = rsp_ofl_q;
  assign rsp_cout_o  = rsp_cout_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Purpose  : Self-checking bench for alu_share_arb. Directed operand vectors
//            with hand-computed results; accepted requests push expected
//            responses into a scoreboard popped as responses are consumed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [1:0]  oper;
    logic        sign;
    logic [31:0] res;
    logic        zero;
    logic        ofl;
    logic        cout;
  } vec_t;

  typedef struct {
    int tag;
    int v;
  } sb_t;

  // Hand-computed vectors: a, b, cin, oper, sign -> res, zero, ofl, cout
  function automatic vec_t vec(input int i);
    case (i)
      0: vec = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 2'b00, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};
      1: vec = '{32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 2'b11, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
      2: vec = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 2'b00, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      3: vec = '{32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 2'b01, 1'b0, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
      4: vec = '{32'h12340000, 32'h00005678, 1'b0, 2'b10, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0};
      5: vec = '{32'h00000005, 32'hFFFFFFF8, 1'b1, 2'b00, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      6: vec = '{32'h80000000, 32'h80000000, 1'b0, 2'b00, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1};
      default: vec = '{32'h00000010, 32'h00000020, 1'b1, 2'b00, 1'b0, 32'h00000031, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

  logic        clk, rst_n;
  logic [1:0]  req_valid, req_ready, req_cin, req_sign, rsp_valid, rsp_ready;
  logic [31:0] a0, a1, b0, b1, rsp_out;
  logic [1:0]  op0, op1;
  logic        rsp_zero, rsp_ofl, rsp_cout;

  alu_share_arb #(.WIDTH(32), .OPER_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req0_a_i(a0), .req1_a_i(a1), .req0_b_i(b0), .req1_b_i(b1),
    .req_cin_i(req_cin), .req0_oper_i(op0), .req1_oper_i(op1),
    .req_sign_i(req_sign),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_out_o(rsp_out), .rsp_zero_o(rsp_zero), .rsp_ofl_o(rsp_ofl),
    .rsp_cout_o(rsp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  int   req_q0[$];
  int   req_q1[$];
  sb_t  sb[$];
  int   gnt_log[$];
  int   cur_vec[2];
  logic [1:0] acc;
  int   mdl_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Requester drivers: present the front of each request queue, advance on accept.
  always @(posedge clk) begin
    vec_t v;
    #3;
    if (acc[0] && req_q0.size() > 0) void'(req_q0.pop_front());
    if (acc[1] && req_q1.size() > 0) void'(req_q1.pop_front());
    acc = 2'b00;
    req_valid[0] = (req_q0.size() > 0);
    req_valid[1] = (req_q1.size() > 0);
    if (req_valid[0]) begin
      cur_vec[0] = req_q0[0];
      v = vec(cur_vec[0]);
      a0 = v.a; b0 = v.b; req_cin[0] = v.cin; op0 = v.oper; req_sign[0] = v.sign;
    end
    if (req_valid[1]) begin
      cur_vec[1] = req_q1[0];
      v = vec(cur_vec[1]);
      a1 = v.a; b1 = v.b; req_cin[1] = v.cin; op1 = v.oper; req_sign[1] = v.sign;
    end
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    sb_t  e;
    vec_t v;
    logic full, drain;
    int   g;
    logic [1:0] exp_rdy;
    if (!rst_n) begin
      sb.delete();
      mdl_last = 1;
      acc = 2'b00;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_out", 64'(rsp_out), 64'(0));
      chk("rst_rsp_flags", 64'({rsp_zero, rsp_ofl, rsp_cout}), 64'(0));
    end else begin
      full  = (sb.size() > 0);
      drain = 1'b0;
      if (full) begin
        e = sb[0];
        v = vec(e.v);
        chk("rsp_valid", 64'(rsp_valid), 64'((e.tag == 1) ? 2'b10 : 2'b01));
        chk("rsp_out", 64'(rsp_out), 64'(v.res));
        chk("rsp_flags", 64'({rsp_zero, rsp_ofl, rsp_cout}), 64'({v.zero, v.ofl, v.cout}));
        drain = rsp_ready[e.tag];
      end else begin
        chk("rsp_idle", 64'(rsp_valid), 64'(0));
      end
      if (req_valid == 2'b11) g = 1 - mdl_last;
      else g = req_valid[1] ? 1 : 0;
      exp_rdy = ((!full || drain) && req_valid != 2'b00) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (drain) void'(sb.pop_front());
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          acc[i] = 1'b1;
          sb.push_back('{tag: i, v: cur_vec[i]});
          mdl_last = i;
          gnt_log.push_back(i);
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    for (int k = 0; k < 200; k++) begin
      if (req_q0.size() == 0 && req_q1.size() == 0 && sb.size() == 0 && req_valid == 2'b00)
        return;
      step();
    end
    n_total++;
    $display("FAIL %s: timeout got busy expected idle", nm);
  endtask

  initial begin
    logic [7:0] ord;
    rst_n = 1'b0; rsp_ready = 2'b00; req_valid = 2'b00; acc = 2'b00;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; op0 = '0; op1 = '0;
    req_cin = '0; req_sign = '0; cur_vec[0] = 0; cur_vec[1] = 0; mdl_last = 1;
    repeat (3) step();
    rst_n = 1'b1;
    rsp_ready = 2'b11;

    // Single-requester operations
    req_q0.push_back(0); wait_idle("single_add_ofl");
    req_q1.push_back(1); wait_idle("single_xor");
    req_q0.push_back(2); wait_idle("single_add_carry");

    // Round-robin alternation after reset
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    gnt_log.delete();
    req_q0.push_back(3); req_q0.push_back(4); req_q0.push_back(5); req_q0.push_back(6);
    req_q1.push_back(7); req_q1.push_back(0); req_q1.push_back(1); req_q1.push_back(2);
    wait_idle("alternation");
    chk("alt_count", 64'(gnt_log.size()), 64'(8));
    ord = '0;
    for (int k = 0; k < gnt_log.size() && k < 8; k++) ord[k] = (gnt_log[k] == 1);
    chk("alt_order", 64'(ord), 64'(8'b10101010));

    // Backpressure, non-owner ready, then same-cycle drain and refill
    rsp_ready = 2'b00;
    gnt_log.delete();
    req_q0.push_back(4); req_q0.push_back(7); req_q1.push_back(5);
    repeat (4) step();
    rsp_ready = 2'b10;
    repeat (2) step();
    rsp_ready = 2'b11;
    wait_idle("backpressure");
    chk("bp_count", 64'(gnt_log.size()), 64'(3));
    ord = '0;
    for (int k = 0; k < gnt_log.size() && k < 8; k++) ord[k] = (gnt_log[k] == 1);
    chk("bp_order", 64'(ord), 64'(8'b00000010));

    // Reset while requester 1's response is held
    rsp_ready = 2'b00;
    req_q1.push_back(1);
    repeat (3) step();
    chk("pre_rst_valid", 64'(rsp_valid), 64'(2'b10));
    req_q0.push_back(2); req_q1.push_back(3);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(rsp_valid), 64'(0));
    chk("rst_async_ready", 64'(req_ready), 64'(0));
    step(); step();
    gnt_log.delete();
    rsp_ready = 2'b11;
    rst_n = 1'b1;
    wait_idle("post_reset");
    chk("post_rst_count", 64'(gnt_log.size()), 64'(2));
    if (gnt_log.size() > 0) chk("post_rst_first_gnt", 64'(gnt_log[0]), 64'(0));
    else chk("post_rst_first_gnt", 64'(1), 64'(0));

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
